// File: rtl/frame_paste_filter.sv
// Pastes a raster-ordered crop stream into a larger frame filled with FILL_VALUE.
// Optional out_last port when FRAME_PASTE_LAST_EN is defined.
module frame_paste_filter #(
  parameter int unsigned PIXEL_BIT_WIDTH = 16,
  parameter int unsigned IN_ROWS         = 48,
  parameter int unsigned IN_COLS         = 48,
  parameter int unsigned OUT_ROWS        = 100,
  parameter int unsigned OUT_COLS        = 160,
  parameter int unsigned Y_1             = 10,
  parameter int unsigned X_1             = 10,
  parameter logic [PIXEL_BIT_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef FRAME_PASTE_LAST_EN
  ,
  output logic                       out_last
`endif
);

  // One spare bit so the window end and wrap-around offsets are representable.
  localparam int unsigned ROW_W = $clog2(OUT_ROWS + 1);
  localparam int unsigned COL_W = $clog2(OUT_COLS + 1);

  localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(Y_1);
  localparam logic [ROW_W-1:0] ROW_SPAN = ROW_W'(IN_ROWS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LO   = COL_W'(X_1);
  localparam logic [COL_W-1:0] COL_SPAN = COL_W'(IN_COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_COLS - 1);

  if ((Y_1 + IN_ROWS > OUT_ROWS) || (X_1 + IN_COLS > OUT_COLS)) begin : g_bad_cfg
    $error("frame_paste_filter: paste window does not fit inside the output frame");
  end

  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] row_nxt;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_off;
  logic [COL_W-1:0] col_off;
  logic             in_win;
  logic             load_en;
  logic             do_load;
  logic             frame_end;

  // Window test by wrapped offset: positions left/above the window wrap past the span.
  always_comb begin
    row_off   = row - ROW_LO;
    col_off   = col - COL_LO;
    in_win    = (row_off < ROW_SPAN) && (col_off < COL_SPAN);
    load_en   = !out_valid || out_ready;
    in_ready  = load_en && in_win;
    do_load   = load_en && (!in_win || in_valid);
    frame_end = (row == ROW_LAST) && (col == COL_LAST);
  end

  // Raster position advance on every load.
  always_comb begin
    row_nxt = row;
    col_nxt = col;
    if (do_load) begin
      if (col == COL_LAST) begin
        col_nxt = '0;
        row_nxt = frame_end ? '0 : row + ROW_W'(1);
      end else begin
        col_nxt = col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      pixel_out <= '0;
    end else begin
      row <= row_nxt;
      col <= col_nxt;
      if (load_en) begin
        // A window position with no input leaves a bubble.
        out_valid <= do_load;
        if (do_load) begin
          pixel_out <= in_win ? pixel_in : FILL_VALUE;
        end
      end
    end
  end

`ifdef FRAME_PASTE_LAST_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_last <= 1'b0;
    end else if (do_load) begin
      out_last <= frame_end;
    end
  end
`endif

endmodule
